fb_read_scheduler: RTL and testbench

Sequences and arbitrates the AXI4 read-address channel of the M00 master in the framebuffer-to-HDMI path.
- Per video line: one line request from the HDMI timing side issues 5 INCR bursts of 64 beats × 64 bit for layer FB0, then 5 for layer FB1.
- Audio bursts are interleaved between FB bursts.
- Only one burst is outstanding at a time.
- Read data is tagged and steered into the line buffer or the audio path.

---
 rtl/fbreader_pkg.sv | 11 +
 rtl/fb_line_addr_gen.sv | 17 +
 rtl/fb_read_scheduler.sv | 99 +++++++++
 tb/tb_fb_read_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fbreader_pkg.sv
// fbreader_pkg: shared constants and FSM encoding for the framebuffer read scheduler
package fbreader_pkg;
   localparam logic [31:0] FB0_BASE = 32'h8100_0000;
   localparam logic [31:0] FB1_BASE = 32'h8112_C000;
   localparam int LINE_BYTES = 2560;
   localparam int BURSTS_PER_LAYER = 5;
   localparam int BURST_LEN = 64;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_8B = 3'b011;
   typedef enum logic [2:0] {IDLE, ARB, AR_FB, R_FB, AR_AUD, R_AUD} state_t;
endpackage

// File: rtl/fb_line_addr_gen.sv
// fb_line_addr_gen: byte address of one framebuffer burst from line index and burst index
module fb_line_addr_gen
   import fbreader_pkg::*;
(
   input  logic [8:0]  line,
   input  logic [3:0]  burst_idx,
   output logic [31:0] addr
);
   logic        layer1;
   logic [31:0] l, sub;
   always_comb begin
      layer1 = burst_idx >= 4'(BURSTS_PER_LAYER);
      l = {23'd0, line};
      sub = {28'd0, layer1 ? burst_idx - 4'(BURSTS_PER_LAYER) : burst_idx};
      addr = (layer1 ? FB1_BASE : FB0_BASE) + (l << 11) + (l << 9) + (sub << 9);
   end
endmodule

// File: rtl/fb_read_scheduler.sv
// fb_read_scheduler: AXI4 read-address sequencer interleaving framebuffer line bursts with audio bursts
module fb_read_scheduler
   import fbreader_pkg::*;
#(
   parameter int ID_WIDTH = 1
) (
   input  logic                m00_axi_aclk,
   input  logic                m00_axi_areset,
   input  logic                line_req,
   input  logic [8:0]          line_num,
   input  logic                aud_req,
   input  logic [31:0]         aud_addr,
   output logic                aud_ack,
   output logic [ID_WIDTH-1:0] m00_axi_arid,
   output logic [31:0]         m00_axi_araddr,
   output logic [7:0]          m00_axi_arlen,
   output logic [2:0]          m00_axi_arsize,
   output logic [1:0]          m00_axi_arburst,
   output logic                m00_axi_arvalid,
   input  logic                m00_axi_arready,
   input  logic                m00_axi_rvalid,
   input  logic                m00_axi_rlast,
   input  logic [1:0]          m00_axi_rresp,
   output logic                m00_axi_rready,
   output logic                lb_we,
   output logic [9:0]          lb_addr,
   output logic                aud_rvalid,
   output logic                line_done,
   output logic                busy,
   output logic                error
);
   state_t      state, state_n;
   logic [8:0]  line;
   logic [3:0]  burst_idx;
   logic [5:0]  beat;
   logic [31:0] fb_addr;
   logic        last_fb, beat_ok, last_beat, fb_end, accept, busy_n, aud_win, fb_win;

   fb_line_addr_gen u_addr (.line(line), .burst_idx(burst_idx), .addr(fb_addr));

   assign m00_axi_arlen = 8'(BURST_LEN - 1);
   assign m00_axi_arsize = SIZE_8B;
   assign m00_axi_arburst = BURST_INCR;
   assign m00_axi_arvalid = state == AR_FB || state == AR_AUD;
   assign m00_axi_rready = state == R_FB || state == R_AUD;
   assign aud_ack = state == AR_AUD && m00_axi_arready;
   assign beat_ok = m00_axi_rvalid && m00_axi_rready;
   assign lb_we = beat_ok && state == R_FB;
   assign aud_rvalid = beat_ok && state == R_AUD;
   assign lb_addr = {burst_idx, beat};
   assign last_beat = beat_ok && m00_axi_rlast;
   assign fb_end = lb_we && m00_axi_rlast && burst_idx == 4'(2 * BURSTS_PER_LAYER - 1);
   // a request landing on the final beat of a line is taken as the next line, not an overrun
   assign accept = line_req && (!busy || fb_end);
   assign busy_n = accept || (busy && !fb_end);
   assign aud_win = state == ARB && aud_req && (last_fb || !busy);
   assign fb_win = state == ARB && !aud_win && busy;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:        state_n = busy || aud_req ? ARB : IDLE;
         ARB:         state_n = aud_win ? AR_AUD : fb_win ? AR_FB : IDLE;
         AR_FB:       state_n = m00_axi_arready ? R_FB : AR_FB;
         AR_AUD:      state_n = m00_axi_arready ? R_AUD : AR_AUD;
         R_FB, R_AUD: state_n = last_beat ? (busy_n || aud_req ? ARB : IDLE) : state;
         default:     state_n = IDLE;
      endcase
   end

   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) begin
         state <= IDLE;
         busy <= 1'b0;
         line <= '0;
         burst_idx <= '0;
         beat <= '0;
         last_fb <= 1'b0;
         error <= 1'b0;
         line_done <= 1'b0;
         m00_axi_araddr <= '0;
         m00_axi_arid <= '0;
      end else begin
         state <= state_n;
         busy <= busy_n;
         line_done <= fb_end;
         error <= error || (line_req && !accept) || (beat_ok && m00_axi_rresp != 2'b00);
         if (accept) line <= line_num;
         if (aud_win || fb_win) begin
            m00_axi_araddr <= aud_win ? aud_addr : fb_addr;
            m00_axi_arid <= ID_WIDTH'(aud_win);
            last_fb <= fb_win;
         end
         if (beat_ok) beat <= m00_axi_rlast ? 6'd0 : beat + 6'd1;
         if (accept || fb_end) burst_idx <= 4'd0;
         else if (lb_we && m00_axi_rlast) burst_idx <= burst_idx + 4'd1;
      end
   end
endmodule

// File: tb/tb_fb_read_scheduler.sv
// tb_fb_read_scheduler: randomized AXI slave plus transaction-level model of the expected AR/R traffic
module tb_fb_read_scheduler;
   logic        clk = 1'b0;
   logic        rst, line_req, aud_req, aud_ack, arvalid, arready, rvalid, rlast, rready;
   logic        lb_we, aud_rvalid, line_done, busy, error;
   logic [8:0]  line_num;
   logic [31:0] aud_addr, araddr;
   logic [0:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;
   logic [9:0]  lb_addr;

   fb_read_scheduler dut (
      .m00_axi_aclk(clk), .m00_axi_areset(rst), .line_req(line_req), .line_num(line_num),
      .aud_req(aud_req), .aud_addr(aud_addr), .aud_ack(aud_ack), .m00_axi_arid(arid),
      .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
      .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
      .m00_axi_rvalid(rvalid), .m00_axi_rlast(rlast), .m00_axi_rresp(rresp),
      .m00_axi_rready(rready), .lb_we(lb_we), .lb_addr(lb_addr), .aud_rvalid(aud_rvalid),
      .line_done(line_done), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic id; logic [31:0] addr;} ar_t;
   ar_t         exp_q[$];
   int          n_cmp = 0, n_bad = 0;
   int          ar_mode, ar_need, ar_wait, r_pct, beats_left, burst_cnt, lb_cnt, exp_lb;
   int          fb_bursts, lines_done;
   bit          ar_pend, cur_aud, exp_done_next, chained, chain_pend, last_pushed_fb;
   bit          err_exp, drop_aud, bad_beat;
   logic [8:0]  chain_line;
   logic [31:0] ar_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] fb_model(input logic [8:0] ln, input int k);
      return (k < 5 ? 32'h8100_0000 : 32'h8112_C000) + ln * 2560 + (k % 5) * 512;
   endfunction

   function automatic int need_for(input int m);
      return m == 1 ? 7 : m == 2 ? int'($urandom_range(3)) : 0;
   endfunction

   // audio is granted first whenever the previous grant was a framebuffer burst
   task automatic push_line(input logic [8:0] ln, input bit aud);
      for (int k = 0; k < 10; k++) begin
         if (aud && last_pushed_fb) exp_q.push_back('{1'b1, aud_addr});
         exp_q.push_back('{1'b0, fb_model(ln, k)});
         last_pushed_fb = 1;
      end
      if (aud) begin
         exp_q.push_back('{1'b1, aud_addr});
         last_pushed_fb = 0;
      end
   endtask

   task automatic set_slave(input int mode, input int pct);
      ar_mode = mode;
      r_pct = pct;
      ar_need = need_for(mode);
   endtask

   task automatic monitor();
      ar_t e;
      bit  exp_done;
      exp_done = exp_done_next;
      exp_done_next = 0;
      if (line_done || exp_done) chk("line_done", line_done, exp_done);
      if (exp_done) begin
         chk("busy_after_line", busy, chained);
         chained = 0;
      end
      if (ar_pend) begin
         chk("ar_hold_valid", arvalid, 1);
         chk("ar_hold_addr", araddr, ar_prev);
      end
      ar_prev = araddr;
      ar_pend = arvalid && !arready;
      if (arvalid && arready) begin
         chk("ar_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("arid", arid, e.id);
            chk("araddr", araddr, e.addr);
            chk("aud_ack", aud_ack, e.id);
            cur_aud = e.id;
            beats_left = 64;
            burst_cnt = 0;
            if (!e.id) fb_bursts++;
            if (e.id && aud_req && exp_q.size() == 0) drop_aud = 1;
         end
         ar_wait = 0;
         ar_need = need_for(ar_mode);
      end else begin
         if (aud_ack) chk("aud_ack_spurious", aud_ack, 0);
         if (arvalid) ar_wait++;
      end
      if (rvalid) begin
         chk("rready", rready, 1);
         if (cur_aud) begin
            chk("aud_rvalid", aud_rvalid, 1);
            chk("lb_we_in_aud", lb_we, 0);
            burst_cnt += int'(aud_rvalid);
         end else begin
            chk("lb_we", lb_we, 1);
            chk("aud_rvalid_in_fb", aud_rvalid, 0);
            chk("lb_addr", lb_addr, exp_lb);
            exp_lb++;
            lb_cnt += int'(lb_we);
            burst_cnt += int'(lb_we);
         end
         bad_beat = 0;
         beats_left--;
         if (beats_left == 0) begin
            chk("burst_beats", burst_cnt, 64);
            if (!cur_aud && fb_bursts == 10) begin
               chk("line_beats", lb_cnt, 640);
               exp_done_next = 1;
               lines_done++;
               lb_cnt = 0;
               exp_lb = 0;
               fb_bursts = 0;
               if (chain_pend) begin
                  line_req = 1;
                  line_num = chain_line;
                  push_line(chain_line, 0);
                  chain_pend = 0;
                  chained = 1;
               end
            end
         end
      end else if (lb_we || aud_rvalid) chk("strobe_spurious", {lb_we, aud_rvalid}, 0);
   endtask

   task automatic step();
      arready = ar_wait >= ar_need;
      rvalid = beats_left > 0 && $urandom_range(99) < r_pct;
      rlast = beats_left == 1;
      rresp = (bad_beat && rvalid) ? 2'b10 : 2'b00;
      #4;
      monitor();
      @(posedge clk);
      #1;
      line_req = 0;
      if (drop_aud) begin
         aud_req = 0;
         drop_aud = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      line_req = 0;
      aud_req = 0;
      arready = 1;
      rvalid = 1;
      rlast = 0;
      rresp = 0;
      @(posedge clk);
      #1;
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_lb_we", lb_we, 0);
      chk("rst_aud_rvalid", aud_rvalid, 0);
      chk("rst_aud_ack", aud_ack, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arid", arid, 0);
      chk("arlen", arlen, 63);
      chk("arsize", arsize, 3'b011);
      chk("arburst", arburst, 2'b01);
      rst = 0;
      rvalid = 0;
      exp_q.delete();
      {beats_left, burst_cnt, lb_cnt, exp_lb, fb_bursts, ar_wait} = '0;
      {ar_pend, cur_aud, exp_done_next, chained, chain_pend, last_pushed_fb} = '0;
      {err_exp, drop_aud, bad_beat} = '0;
   endtask

   task automatic run_line(input logic [8:0] ln, input bit aud, input bit ovr, input bit bad,
                           input int rst_at, input bit chain, input logic [8:0] ln2);
      int target, cyc;
      bit ovr_done;
      push_line(ln, aud);
      target = lines_done + (chain ? 2 : 1);
      chain_pend = chain;
      chain_line = ln2;
      bad_beat = bad;
      if (bad) err_exp = 1;
      line_num = ln;
      line_req = 1;
      aud_req = aud;
      cyc = 0;
      ovr_done = 0;
      while ((lines_done < target || exp_q.size() != 0 || beats_left != 0 || aud_req) && cyc < 6000) begin
         if (rst_at > 0 && lb_cnt >= rst_at) begin
            chk("pre_reset_rready", rready, 1);
            return;
         end
         if (ovr && !ovr_done && fb_bursts == 3) begin
            line_num = 9'($urandom_range(479));
            line_req = 1;
            ovr_done = 1;
            err_exp = 1;
         end
         step();
         cyc++;
      end
      chk("timeout", cyc < 6000, 1);
      repeat (6) step();
      chk("busy_idle", busy, 0);
      chk("error", error, err_exp);
   endtask

   initial begin
      lines_done = 0;
      aud_addr = 32'h8000_0000;
      set_slave(0, 100);
      do_reset();
      run_line(0, 0, 0, 0, 0, 0, 0);
      run_line(479, 0, 0, 0, 0, 0, 0);
      run_line(9'($urandom_range(479)), 1, 0, 0, 0, 0, 0);
      set_slave(1, 60);
      run_line(9'($urandom_range(479)), 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         set_slave($urandom_range(2), $urandom_range(50, 100));
         aud_addr = {$urandom_range(32'hFFFF), 16'h0000};
         run_line(9'($urandom_range(479)), 1'($urandom_range(1)), 0, 0, 0, 0, 0);
      end
      set_slave(2, 80);
      run_line(9'($urandom_range(479)), 0, 0, 0, 0, 1, 9'($urandom_range(479)));
      run_line(9'($urandom_range(479)), 0, 1, 0, 0, 0, 0);
      do_reset();
      run_line(9'($urandom_range(479)), 0, 0, 1, 0, 0, 0);
      do_reset();
      run_line(5, 0, 0, 0, 100, 0, 0);
      do_reset();
      run_line(3, 0, 0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
